// File: rtl/rf_wb_arbiter.sv
// Write-port arbiter between pipeline writeback and the long-latency unit, with starvation forcing.
// Optional busy-bit scoreboard for RAW/WAW hazards is built when RF_ARB_SCOREBOARD_EN is defined.
module rf_wb_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_wa,
  input  logic [31:0] pipe_wd,
  output logic        pipe_hold,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_wa,
  input  logic [31:0] lu_wd,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd_chk,
  output logic        hazard,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd
);

  // state  | meaning
  // IDLE   | no lu result losing arbitration
  // WAIT   | lu result has lost wait_cnt consecutive cycles
  // FORCE  | pipeline held off, lu owns the write port
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FORCE} state_t;

  localparam logic [3:0] MAX_W4 = 4'(MAX_WAIT);

  state_t     state;
  logic [3:0] wait_cnt;
  logic       force_own;
  logic       lu_grant;
  logic       pipe_grant;

  always_comb begin
    force_own  = (state == ST_FORCE);
    lu_grant   = lu_valid & (force_own | ~pipe_we);
    pipe_grant = pipe_we & ~force_own & ~lu_grant;
    rf_wa      = lu_grant ? lu_wa : pipe_wa;
    rf_wd      = lu_grant ? lu_wd : pipe_wd;
    rf_we      = (lu_grant | pipe_grant) & (rf_wa != 5'd0);
  end

  assign lu_ready = lu_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      pipe_hold <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (lu_valid && pipe_we) begin
            wait_cnt <= 4'd1;
            // MAX_WAIT of 1 tolerates only this single lost cycle
            if (MAX_W4 == 4'd1) begin
              state     <= ST_FORCE;
              pipe_hold <= 1'b1;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (lu_grant || !lu_valid) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
            if (wait_cnt == MAX_W4 - 4'd1) begin
              state     <= ST_FORCE;
              pipe_hold <= 1'b1;
            end
          end
        end
        ST_FORCE: begin
          if (lu_grant) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            pipe_hold <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          wait_cnt  <= 4'd0;
          pipe_hold <= 1'b0;
        end
      endcase
    end
  end

`ifdef RF_ARB_SCOREBOARD_EN
  logic [31:1] busy;
  logic [31:0] busy_vec;

  assign busy_vec = {busy, 1'b0};

  // a same-cycle issue to the register being returned keeps it busy
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (issue_valid && issue_rd == 5'(i))
          busy[i] <= 1'b1;
        else if (lu_grant && lu_wa == 5'(i))
          busy[i] <= 1'b0;
      end
    end
  end

  assign hazard = busy_vec[rs1] | busy_vec[rs2] | busy_vec[rd_chk];
`else
  logic unused_sb;
  assign unused_sb = ^{issue_valid, issue_rd, rs1, rs2, rd_chk};
  assign hazard    = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios followed by randomized traffic,
// all compared against a lost-cycle / busy-set reference model.
module tb_rf_wb_arbiter;
  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_wa;
  logic [31:0] pipe_wd;
  logic        pipe_hold;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_wa;
  logic [31:0] lu_wd;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1, rs2, rd_chk;
  logic        hazard;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  rf_wb_arbiter #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd), .pipe_hold(pipe_hold),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_wa(lu_wa), .lu_wd(lu_wd),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .rd_chk(rd_chk), .hazard(hazard),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: consecutive lost cycles of the pending lu result, and the set of owed registers
  int   lost;
  bit   busy_m [32];
  bit   ready_m;
  logic [31:0] regs [32];

`ifdef RF_ARB_SCOREBOARD_EN
  localparam bit SB_ON = 1'b1;
`else
  localparam bit SB_ON = 1'b0;
`endif

  always @(posedge clk) if (rf_we) regs[rf_wa] <= rf_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit hold_e, we_e, haz_e;
    logic [4:0]  wa_e;
    logic [31:0] wd_e;
    hold_e  = (lost >= MW);
    ready_m = lu_valid & (hold_e | ~pipe_we);
    we_e = 1'b0; wa_e = '0; wd_e = '0;
    if (ready_m) begin
      we_e = (lu_wa != 0); wa_e = lu_wa; wd_e = lu_wd;
    end else if (pipe_we && !hold_e) begin
      we_e = (pipe_wa != 0); wa_e = pipe_wa; wd_e = pipe_wd;
    end
    haz_e = SB_ON & (busy_m[rs1] | busy_m[rs2] | busy_m[rd_chk]);
    chk("pipe_hold", pipe_hold, hold_e);
    chk("lu_ready", lu_ready, ready_m);
    chk("rf_we", rf_we, we_e);
    if (we_e) begin
      chk("rf_wa", rf_wa, wa_e);
      chk("rf_wd", rf_wd, wd_e);
    end
    chk("hazard", hazard, haz_e);
  endtask

  task automatic tick(input bit do_chk = 1'b1);
    #1;
    if (do_chk) check_outputs();
    @(posedge clk);
    if (rst) begin
      lost = 0;
      foreach (busy_m[i]) busy_m[i] = 1'b0;
    end else begin
      if (lu_valid && !ready_m) lost++;
      else lost = 0;
      if (ready_m) busy_m[lu_wa] = 1'b0;
      if (issue_valid && issue_rd != 0) busy_m[issue_rd] = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    int waited;
    rst = 1'b1; pipe_we = 0; pipe_wa = 0; pipe_wd = 0; lu_valid = 0; lu_wa = 0; lu_wd = 0;
    issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0; rd_chk = 0;
    lost = 0; ready_m = 0;
    foreach (busy_m[i]) busy_m[i] = 1'b0;
    @(negedge clk);
    tick(1'b0);
    tick(1'b0);
    rst = 1'b0;

    // reset state
    rs1 = 9; rs2 = 12; rd_chk = 3;
    #1;
    chk("rst_hold", pipe_hold, 0);
    chk("rst_hazard", hazard, 0);
    chk("rst_ready", lu_ready, 0);
    tick();
    rs1 = 0; rs2 = 0; rd_chk = 0;

    // pipeline priority until starvation forces a yield
    pipe_we = 1; pipe_wa = 5; pipe_wd = 32'hAAAA_0000;
    lu_valid = 1; lu_wa = 7; lu_wd = 32'h7777_0007;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk("prio_wa", rf_wa, 5);
      chk("prio_ready", lu_ready, 0);
      tick();
    end
    #1;
    chk("force_hold", pipe_hold, 1);
    chk("force_wa", rf_wa, 7);
    chk("force_wd", rf_wd, 32'h7777_0007);
    chk("force_ready", lu_ready, 1);
    tick();
    lu_valid = 0;
    #1;
    chk("force_release", pipe_hold, 0);
    tick();
    pipe_we = 0;

    // idle grant and register file commit
    lu_valid = 1; lu_wa = 3; lu_wd = 32'h1234;
    #1;
    chk("idle_we", rf_we, 1);
    chk("idle_wa", rf_wa, 3);
    chk("idle_wd", rf_wd, 32'h1234);
    chk("idle_ready", lu_ready, 1);
    tick();
    lu_valid = 0;
    tick();
    chk("reg3", regs[3], 32'h1234);

    // x0 writes are dropped
    lu_valid = 1; lu_wa = 0; lu_wd = 32'hDEAD;
    #1;
    chk("x0_lu_ready", lu_ready, 1);
    chk("x0_lu_we", rf_we, 0);
    tick();
    lu_valid = 0; pipe_we = 1; pipe_wa = 0; pipe_wd = 32'hBEEF;
    #1;
    chk("x0_pipe_we", rf_we, 0);
    tick();
    pipe_we = 0;

    // scoreboard set / clear / set-wins
    issue_valid = 1; issue_rd = 9;
    tick();
    issue_valid = 0; rs1 = 9;
    #1;
    chk("sb_set", hazard, SB_ON);
    tick();
    lu_valid = 1; lu_wa = 9; lu_wd = 32'h99;
    tick();
    lu_valid = 0;
    #1;
    chk("sb_clr", hazard, 0);
    tick();
    issue_valid = 1; issue_rd = 9; lu_valid = 1; lu_wa = 9;
    tick();
    issue_valid = 0; lu_valid = 0;
    #1;
    chk("sb_setwins", hazard, SB_ON);
    tick();
    lu_valid = 1; lu_wa = 9;
    tick();
    lu_valid = 0; rs1 = 0;
    tick();

    // reset while in FORCE
    issue_valid = 1; issue_rd = 12;
    tick();
    issue_valid = 0; rs2 = 12;
    pipe_we = 1; pipe_wa = 6; pipe_wd = 32'h6666;
    lu_valid = 1; lu_wa = 8; lu_wd = 32'h8888;
    for (int c = 1; c <= 4; c++) tick();
    #1;
    chk("pre_rst_hold", pipe_hold, 1);
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("post_rst_hold", pipe_hold, 0);
    chk("post_rst_hazard", hazard, 0);
    chk("post_rst_ready", lu_ready, 0);
    waited = 0;
    while (lu_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
      #1;
    end
    chk("rst_restart_wait", waited, MW);
    tick();
    lu_valid = 0; pipe_we = 0; rs2 = 0;
    tick();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if (!lu_valid && $urandom_range(0, 2) == 0) begin
        lu_valid = 1;
        lu_wa = 5'($urandom_range(0, 31));
        lu_wd = $urandom;
      end
      if (lost >= MW) pipe_we = ($urandom_range(0, 15) == 0);
      else            pipe_we = 1'($urandom_range(0, 1));
      pipe_wa     = 5'($urandom_range(0, 31));
      pipe_wd     = $urandom;
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_rd    = 5'($urandom_range(0, 31));
      rs1         = 5'($urandom_range(0, 31));
      rs2         = 5'($urandom_range(0, 31));
      rd_chk      = 5'($urandom_range(0, 31));
      tick();
      if (ready_m) lu_valid = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter and scoreboard for the 32×32 integer register file, which has one write port and two read ports. It shares the single write port between two sources: the in-order pipeline writeback, which normally has priority, and a long-latency unit (mul/div/load-miss return) that uses a valid/ready handshake. A starvation counter guarantees the long-latency unit eventually gets the port. An optional busy-bit scoreboard tracks destinations still owed by the long-latency unit and reports RAW/WAW hazards to the decode stage.

## Interface
- MAX_WAIT, 4: consecutive lost-arbitration cycles tolerated before the pipeline is forced to yield; legal range 1–15.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pipe_we  in  1  pipeline writeback request; has no backpressure except via pipe_hold.
- pipe_wa  in  5  pipeline destination register.
- pipe_wd  in  32  pipeline write data.
- pipe_hold  out  1  registered; pipeline must not assert pipe_we in any cycle where this is 1.
- lu_valid  in  1  long-latency result valid; held with lu_wa/lu_wd stable until accepted.
- lu_ready  out  1  long-latency result accepted this cycle.
- lu_wa  in  5  long-latency destination register.
- lu_wd  in  32  long-latency result.
- issue_valid  in  1  a long-latency op issues this cycle.
- issue_rd  in  5  destination of the issuing op.
- rs1, rs2, rd_chk  in  5 each  decode-stage source and destination registers.
- hazard  out  1  combinational; decode must stall.
- rf_we  out  1  register file write enable.
- rf_wa  out  5  register file write address.
- rf_wd  out  32  register file write data.

## Operation
- Write-port mux:
  - rf_* are combinational from the granted source.
  - rf_we is 0 whenever the granted address is 0.
  - A lu handshake targeting x0 still completes (lu_ready=1) with no write.
- Arbitration FSM, states IDLE, WAIT, FORCE; wait_cnt is 4 bits:
  - IDLE:
    - lu_ready = lu_valid & ~pipe_we.
    - lu_valid & pipe_we → WAIT, wait_cnt=1.
  - WAIT:
    - lu_ready = lu_valid & ~pipe_we.
    - On grant → IDLE, wait_cnt=0.
    - Otherwise wait_cnt++.
    - When wait_cnt would reach MAX_WAIT → FORCE.
  - FORCE:
    - pipe_hold=1; lu_ready=lu_valid; lu owns the port.
    - pipe_we asserted in FORCE is a protocol violation; lu still wins and the pipe write is dropped.
    - On handshake → IDLE, wait_cnt=0.
- pipe_hold is 1 exactly in cycles where state==FORCE; it is driven from the registered state.
- rst overrides every state: IDLE, wait_cnt=0, pipe_hold=0, scoreboard cleared. This includes reset mid-WAIT or mid-FORCE.
- Scoreboard (busy[31:1]):
  - Set on issue_valid with issue_rd≠0.
  - Cleared on lu handshake for lu_wa.
  - If set and clear target the same register in the same cycle, set wins.
  - hazard = busy[rs1] | busy[rs2] | busy[rd_chk]; index 0 always reads 0.

## Timing
- Grant, lu_ready and rf_* are same-cycle combinational; the register file commits at the next rising edge.
- Read-after-write forwarding is handled in the register file, so no extra cycles are added here.
- Worst-case lu wait before acceptance: MAX_WAIT+1 cycles after lu_valid rises under continuous pipe_we.
- Busy bit updates:
  - A bit set by issue is visible on hazard the next cycle.
  - A bit cleared by the lu handshake is visible the next cycle.
- Reset values:
  - pipe_hold=0 and busy=0.
  - lu_ready and hazard follow their inputs combinationally: lu_ready=lu_valid&~pipe_we, hazard=0.

## Configuration
- RF_ARB_SCOREBOARD_EN defined: busy bits, issue_* handling and hazard are built as described.
- RF_ARB_SCOREBOARD_EN undefined:
  - No scoreboard flops; hazard is tied to 0.
  - issue_*, rs1, rs2 and rd_chk are ignored.
  - Arbitration logic is unchanged.

## Test plan
- Priority: pipe_we=1, pipe_wa=5, pipe_wd=0xAAAA0000, lu_valid=1, lu_wa=7, MAX_WAIT=4.
  - Response: rf_wa=5 and lu_ready=0 for 4 cycles.
  - Cycle 5: pipe_hold=1, rf_wa=7, rf_wd=lu_wd, lu_ready=1.
  - Next cycle: pipe_hold=0.
- Idle grant: pipe_we=0, lu_valid=1, lu_wa=3, lu_wd=0x1234 → same cycle rf_we=1, rf_wa=3, rf_wd=0x1234, lu_ready=1; reg3 reads 0x1234 afterwards.
- x0 drop: lu_valid=1, lu_wa=0 → lu_ready=1, rf_we=0, no busy change; pipe_wa=0 with pipe_we=1 → rf_we=0.
- Scoreboard: issue rd=9; next cycle rs1=9 → hazard=1.
  - lu handshake to 9 → hazard=0 the following cycle.
  - Issue rd=9 in the same cycle as the lu handshake to 9 → busy[9] stays 1.
- Reset mid-FORCE: drive to FORCE, assert rst one cycle → pipe_hold=0, state IDLE, busy all 0, the next conflict restarts wait_cnt at 1.
- Macro off: repeat the scoreboard test → hazard stays 0; the arbitration test gives results identical to the macro-on case.
